// File: rtl/uart_tx_serial.sv
// uart_tx_serial: 8N1 UART transmitter, RCONST clk100 cycles per bit, registered tx/busy
module uart_tx_serial #(
  parameter int RCONST = 868
) (
  input  logic       clk100,
  input  logic       reset,
  input  logic [7:0] sbyte,
  input  logic       send,
  output logic       tx,
  output logic       busy
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [7:0] data, data_n;
  logic [3:0] idx, idx_n;
  logic [15:0] cnt, cnt_n;
  logic tx_n, last;
  assign last = cnt == 16'(RCONST - 1);
  assign busy = state == SHIFT;
  // idx counts the bit currently on the line: 0 start, 1..8 data, 9 stop
  always_comb begin
    state_n = state;
    data_n = data;
    idx_n = idx;
    cnt_n = cnt;
    tx_n = tx;
    if (state == IDLE) begin
      if (send) begin
        state_n = SHIFT;
        data_n = sbyte;
        idx_n = 4'd0;
        cnt_n = 16'd0;
        tx_n = 1'b0;
      end
    end else if (!last) begin
      cnt_n = cnt + 16'd1;
    end else begin
      cnt_n = 16'd0;
      state_n = idx == 4'd9 ? IDLE : SHIFT;
      idx_n = idx == 4'd9 ? 4'd0 : idx + 4'd1;
      tx_n = idx >= 4'd8 ? 1'b1 : data[idx[2:0]];
    end
  end
  always_ff @(posedge clk100) begin
    if (reset) begin
      state <= IDLE;
      data <= 8'd0;
      idx <= 4'd0;
      cnt <= 16'd0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      data <= data_n;
      idx <= idx_n;
      cnt <= cnt_n;
      tx <= tx_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_serial.sv
// tb_uart_tx_serial: randomized self-checking bench against a slot-based line model
module tb_uart_tx_serial;
  localparam int R = 108;
  localparam int F = 10 * R;
  logic clk100 = 1'b0, reset = 1'b1, send = 1'b0;
  logic [7:0] sbyte = 8'd0;
  logic tx, busy;
  int cmps = 0, fails = 0;
  logic [7:0] msg [19] = '{8'h41, 8'h44, 8'h54, 8'h42, 8'h43, 8'h44, 8'h43, 8'h44, 8'h45, 8'h46,
                           8'h0D, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49};

  uart_tx_serial #(.RCONST(R)) dut (.clk100(clk100), .reset(reset), .sbyte(sbyte), .send(send),
                                    .tx(tx), .busy(busy));

  always #5 clk100 = ~clk100;

  // Line level k cycles after the accepting edge: slot 0 start, 1..8 data LSB first, then mark
  function automatic logic exp_tx(input logic [7:0] b, input int k);
    int s;
    s = k / R;
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int k);
    return k < F;
  endfunction

  task automatic step();
    @(posedge clk100);
    #1;
  endtask

  task automatic accept(input logic [7:0] b);
    sbyte = b;
    send = 1'b1;
    step();
    send = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      cmps++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold cyc=%0d tx=%b busy=%b want tx=1 busy=0", i, tx, busy);
        break;
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      cmps++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        fails++;
        $display("FAIL idle_no_send cyc=%0d tx=%b busy=%b want tx=1 busy=0", i, tx, busy);
        break;
      end
    end
  endtask

  task automatic test_single();
    accept(8'h41);
    for (int k = 0; k <= F + 5; k++) begin
      if (k > 0) step();
      cmps++;
      if (tx !== exp_tx(8'h41, k) || busy !== exp_busy(k)) begin
        fails++;
        $display("FAIL single_frame k=%0d tx=%b busy=%b want tx=%b busy=%b", k, tx, busy,
                 exp_tx(8'h41, k), exp_busy(k));
        break;
      end
    end
  endtask

  task automatic test_roundtrip();
    logic [9:0] rx;
    int t;
    for (int m = 0; m < 19; m++) begin
      t = 0;
      while (busy && t < 2 * F) begin
        step();
        t++;
      end
      cmps++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL rt_wait_idle byte=%0d busy=%b want 0", m, busy);
      end
      accept(msg[m]);
      rx = '0;
      for (int k = 0; k < F; k++) begin
        if (k > 0) step();
        if (k % R == R / 2) rx[k/R] = tx;
      end
      cmps++;
      if (rx[0] !== 1'b0 || rx[9] !== 1'b1 || rx[8:1] !== msg[m]) begin
        fails++;
        $display("FAIL rt_byte idx=%0d got=%h start=%b stop=%b want=%h start=0 stop=1", m,
                 rx[8:1], rx[0], rx[9], msg[m]);
      end
      step();
      cmps++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
        fails++;
        $display("FAIL rt_end idx=%0d busy=%b tx=%b want busy=0 tx=1", m, busy, tx);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int gap;
    for (int n = 0; n < 6; n++) begin
      b = 8'($urandom);
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) step();
      accept(b);
      for (int k = 0; k <= F; k++) begin
        if (k > 0) step();
        cmps++;
        if (tx !== exp_tx(b, k) || busy !== exp_busy(k)) begin
          fails++;
          $display("FAIL random_frame b=%h k=%0d tx=%b busy=%b want tx=%b busy=%b", b, k, tx,
                   busy, exp_tx(b, k), exp_busy(k));
          break;
        end
        sbyte = 8'($urandom);
        send = k < F && $urandom_range(0, 15) == 0;
      end
      send = 1'b0;
    end
  endtask

  task automatic test_send_busy();
    accept(8'h55);
    for (int k = 0; k <= F; k++) begin
      if (k > 0) step();
      cmps++;
      if (tx !== exp_tx(8'h55, k) || busy !== exp_busy(k)) begin
        fails++;
        $display("FAIL send_while_busy k=%0d tx=%b busy=%b want tx=%b busy=%b", k, tx, busy,
                 exp_tx(8'h55, k), exp_busy(k));
        break;
      end
      sbyte = k == 300 ? 8'hFF : sbyte;
      send = k == 300;
    end
    send = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    accept(8'h00);
    for (int k = 0; k <= 500; k++) begin
      if (k > 0) step();
      cmps++;
      if (tx !== exp_tx(8'h00, k) || busy !== 1'b1) begin
        fails++;
        $display("FAIL pre_abort k=%0d tx=%b busy=%b want tx=%b busy=1", k, tx, busy,
                 exp_tx(8'h00, k));
        break;
      end
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    cmps++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_edge tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
    step();
    cmps++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL after_abort tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
    b = 8'($urandom);
    accept(b);
    for (int k = 0; k <= F; k++) begin
      if (k > 0) step();
      cmps++;
      if (tx !== exp_tx(b, k) || busy !== exp_busy(k)) begin
        fails++;
        $display("FAIL clean_frame b=%h k=%0d tx=%b busy=%b want tx=%b busy=%b", b, k, tx, busy,
                 exp_tx(b, k), exp_busy(k));
        break;
      end
    end
  endtask

  task automatic test_held();
    int f;
    sbyte = 8'hA5;
    send = 1'b1;
    step();
    for (int k = 0; k < 3 * (F + 1); k++) begin
      if (k > 0) step();
      f = k % (F + 1);
      cmps++;
      if (tx !== exp_tx(8'hA5, f) || busy !== exp_busy(f)) begin
        fails++;
        $display("FAIL held_send k=%0d tx=%b busy=%b want tx=%b busy=%b", k, tx, busy,
                 exp_tx(8'hA5, f), exp_busy(f));
        break;
      end
    end
    send = 1'b0;
    step();
    cmps++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL held_release tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_roundtrip();
    test_random();
    test_send_busy();
    test_reset_mid();
    test_held();
    $display("End of test - %0d assertions evaluated, %0d failures", cmps, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_serial.md
Name: uart_tx_serial

Overview:
- 8N1 asynchronous serial (UART) transmitter.
- Takes a byte on a one-cycle `send` strobe and shifts it out on `tx`. The frame is one start bit, eight data bits LSB-first, and one stop bit.
- Used for the host serial link of the board top level and as a stimulus driver for the board's serial receiver in simulation.
- Bit timing is a fixed integer number of `clk100` cycles per bit, set by a parameter.

Parameters:
- RCONST, default 868: clk100 cycles per serial bit (868 gives 115200 baud at 100 MHz; simulation uses 108). Legal range is 2 to 65535.

Ports:
- clk100  input  1  system clock (100 MHz nominal); the only clock in the block.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk100.
- sbyte  input  8  byte to transmit; sampled only on the accepting edge.
- send  input  1  transmit request strobe, level-sampled each rising edge.
- tx  output  1  serial line output; idle/mark level is 1.
- busy  output  1  high while a frame is in progress.

Behaviour:
- All state is updated on the rising edge of clk100. There are no combinational paths from inputs to outputs; tx and busy are registered.
- Reset:
  - When reset=1 at an edge: tx<=1, busy<=0, bit counter<=0, cycle counter<=0.
  - Reset has priority over everything, including a frame in progress, which is aborted immediately. The line returns to 1 at that edge.
- States: IDLE, then SHIFT (covers start, data, and stop bits), then back to IDLE. busy=1 exactly while in SHIFT.
- Accept:
  - In IDLE, an edge with send=1 latches sbyte into a shift register.
  - At that same edge: tx<=0 (start bit), busy<=1, cycle counter<=0, bit index<=0.
  - Latency from the accepting edge to tx falling is 0 cycles; both change at the accepting edge.
- Bit timing:
  - Each bit holds tx constant for exactly RCONST clk100 cycles.
  - Bit order: start bit (0), then d0..d7 (LSB first), then stop bit (1).
  - tx changes only at bit boundaries, i.e. every RCONST cycles after the accepting edge.
- Completion:
  - After the stop bit has been driven for RCONST cycles, busy<=0 and the state returns to IDLE.
  - tx remains 1.
  - busy is therefore high for exactly 10*RCONST consecutive cycles per frame.
- Ignored send:
  - send=1 while busy=1 is ignored: no queuing, no restart.
  - sbyte changes during a frame have no effect.
- Back-to-back frames:
  - send=1 on the edge at which busy returns to 0 is not accepted; acceptance requires busy=0 before the edge.
  - The earliest next start bit is therefore 1 cycle after busy falls, giving at least one extra idle cycle of stop level.
- Held send: if send is held high continuously, a new frame starts on the first edge where busy=0.
- Counter sizing: the cycle counter is wide enough for RCONST-1 (16 bits is sufficient). Counter wrap beyond RCONST-1 never occurs.

Test Plan:
- Reset then idle: reset=1 for 20 cycles, then 0. Required: tx=1 and busy=0 throughout; no activity without send.
- Single frame, RCONST=108: one-cycle send with sbyte=8'h41 ("A").
  - busy=1 from the accepting edge for exactly 1080 cycles.
  - tx sequence per 108-cycle slot: 0, 1,0,0,0,0,0,1,0, 1.
  - tx=1 afterwards.
- Receiver round trip, RCONST=108: connect to the board receiver and send "A","D","T","B","C","D","C","D","E","F",8'h0D,"B".."I", each after busy drops. Required: every byte is received intact, and the receiver never sees a framing error.
- Send while busy: start a frame with 8'h55 and pulse send with 8'hFF at cycle 300. Required: the waveform remains 8'h55 and busy still falls at cycle 1080.
- Reset mid-frame: start a frame with 8'h00 and assert reset at cycle 500. Required: tx=1 and busy=0 at the next edge; the next send starts a clean frame with the full 1080-cycle busy period.
- Held send: send=1 continuously with sbyte=8'hA5. Required: consecutive frames, each 1080 cycles of busy, separated by exactly 1 idle cycle with tx=1.
